// File: rtl/uart_byte_tx.sv
// 8N1 serial byte transmitter with a one-entry holding register so frames can
// leave back-to-back; every output is registered and driven from next-state logic.
//
// Handshake: a byte is accepted on any rising edge where tx_wr=1 and either the
// FSM is idle, the holding register is empty, or the current stop bit ends on
// that same edge; otherwise the byte is dropped and tx_overrun pulses for one
// cycle. tx_ready=1 promises that the next tx_wr will be accepted.
module uart_byte_tx #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       tx_ready,
  output logic       tx_overrun,
  output logic       txd,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic bit_end;
  logic frame_end;

  assign bit_end   = (timer_q == BIT_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    ovr_d      = 1'b0;

    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_wr) begin
          state_d = S_START;
          shift_d = tx_data;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      default: begin
        // End of stop bit: chain straight into the next frame when one is waiting.
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_vld_q) begin
            state_d    = S_START;
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            txd_d      = 1'b0;
          end else if (tx_wr) begin
            state_d = S_START;
            shift_d = tx_data;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
    endcase

    // Writes while a frame is in flight go to the holding register; at frame end
    // the hold slot is freed in the same cycle, so a write there never overruns.
    if (tx_wr && (state_q != S_IDLE) && !(frame_end && !hold_vld_q)) begin
      if (!hold_vld_q || frame_end) begin
        hold_d     = tx_data;
        hold_vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d  = (state_d != S_IDLE) || hold_vld_d;
    ready_d = !hold_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign txd        = txd_q;
  assign tx_done    = done_q;
  assign tx_busy    = busy_q;
  assign tx_ready   = ready_q;
  assign tx_overrun = ovr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: per-cycle comparison against a frame-timeline model,
// plus a line receiver that decodes txd and checks bytes against an expected queue.
module tb_uart_byte_tx;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       tx_busy;
  logic       tx_ready;
  logic       tx_overrun;
  logic       txd;
  logic [1:0] dbg_state;

  uart_byte_tx #(.CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_done    (tx_done),
    .tx_busy    (tx_busy),
    .tx_ready   (tx_ready),
    .tx_overrun (tx_overrun),
    .txd        (txd),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: frame described by its start cycle and byte
  int         m_t     = 0;
  bit         m_act   = 0;
  int         m_start = 0;
  logic [7:0] m_byte  = 8'h00;
  bit         m_hv    = 0;
  logic [7:0] m_hold  = 8'h00;
  bit         m_done  = 0;
  bit         m_ovr   = 0;

  // scoreboard
  logic [7:0] exp_q[$];
  bit         rx_act  = 0;
  int         rx_cnt  = 0;
  logic [7:0] rx_byte = 8'h00;
  int         done_cnt = 0;
  int         ovr_cnt  = 0;
  int         done_t[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_t);
    end
  endtask

  task automatic model_start(input logic [7:0] b);
    m_act   = 1;
    m_start = m_t;
    m_byte  = b;
    exp_q.push_back(b);
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
    m_t++;
    m_done = 0;
    m_ovr  = 0;
    if (!r) begin
      m_act = 0;
      m_hv  = 0;
      return;
    end
    if (m_act && (m_t - m_start == 10 * DIV)) begin
      m_done = 1;
      m_act  = 0;
      if (m_hv) begin
        m_hv = 0;
        model_start(m_hold);
      end
    end
    if (w) begin
      if (!m_act) model_start(d);
      else if (!m_hv) begin
        m_hv   = 1;
        m_hold = d;
      end else m_ovr = 1;
    end
  endtask

  function automatic logic exp_txd();
    int pos;
    if (!m_act) return 1'b1;
    pos = (m_t - m_start) / DIV;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_byte[pos-1];
    return 1'b1;
  endfunction

  task automatic rx_sample(input logic r);
    int k;
    logic [7:0] e;
    if (!r) begin
      rx_act = 0;
      exp_q.delete();
      return;
    end
    if (!rx_act) begin
      if (txd === 1'b0) begin
        rx_act = 1;
        rx_cnt = 0;
      end
      return;
    end
    rx_cnt++;
    if (rx_cnt % DIV == DIV / 2) begin
      k = rx_cnt / DIV;
      if (k >= 1 && k <= 8) rx_byte[k-1] = txd;
      if (k == 9) begin
        chk("stop_bit", 32'(txd), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : ~rx_byte;
        chk("rx_byte", 32'(rx_byte), 32'(e));
        rx_act = 0;
      end
    end
  endtask

  // driver: one clock cycle with the given inputs, then compare at negedge
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    tx_wr   = w;
    tx_data = d;
    rst     = r;
    @(posedge clk);
    model_edge(w, d, r);
    @(negedge clk);
    chk("txd", 32'(txd), 32'(exp_txd()));
    chk("tx_done", 32'(tx_done), 32'(m_done));
    chk("tx_busy", 32'(tx_busy), 32'(m_act || m_hv));
    chk("tx_ready", 32'(tx_ready), 32'(!m_hv));
    chk("tx_overrun", 32'(tx_overrun), 32'(m_ovr));
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_t.push_back(m_t);
    end
    if (tx_overrun === 1'b1) ovr_cnt++;
    rx_sample(r);
    tx_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b1);
  endtask

  logic [7:0] pkt[6];
  int         pi;

  initial begin
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    rst     = 1'b0;

    // reset and idle line
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    idle(50);
    chk("idle_no_done", 32'(done_cnt), 32'd0);

    // single frame 0x55
    done_t.delete();
    wr(8'h55);
    idle(45);
    chk("f55_done_cnt", 32'(done_t.size()), 32'd1);

    // back-to-back A3 then 0F
    done_t.delete();
    wr(8'hA3);
    idle(4);
    wr(8'h0F);
    idle(85);
    chk("b2b_done_cnt", 32'(done_t.size()), 32'd2);
    if (done_t.size() == 2) chk("b2b_gap", 32'(done_t[1] - done_t[0]), 32'd40);

    // overrun: 0x33 dropped
    done_t.delete();
    ovr_cnt = 0;
    wr(8'h11);
    idle(2);
    wr(8'h22);
    idle(3);
    wr(8'h33);
    idle(85);
    chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
    chk("ovr_done_cnt", 32'(done_t.size()), 32'd2);

    // write coinciding with frame end, hold empty then hold full
    wr(8'h3C);
    idle(39);
    wr(8'hC3);
    idle(2);
    wr(8'h5A);
    idle(37);
    wr(8'h96);
    idle(90);

    // reset mid-frame, then a clean frame
    done_t.delete();
    wr(8'hFF);
    idle(16);
    step(1'b0, 8'h00, 1'b0);
    idle(3);
    chk("abort_no_done", 32'(done_t.size()), 32'd0);
    wr(8'hFF);
    idle(45);
    chk("after_abort_done", 32'(done_t.size()), 32'd1);

    // packet-style feed, paced by tx_ready
    pkt[0] = 8'hD5; pkt[1] = 8'h03; pkt[2] = 8'h01;
    pkt[3] = 8'h02; pkt[4] = 8'h03; pkt[5] = 8'hD8;
    pi = 0;
    done_t.delete();
    ovr_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (pi < 6 && tx_ready === 1'b1) begin
        wr(pkt[pi]);
        pi++;
      end else idle(1);
    end
    chk("pkt_all_sent", 32'(pi), 32'd6);
    chk("pkt_done_cnt", 32'(done_t.size()), 32'd6);
    chk("pkt_no_ovr", 32'(ovr_cnt), 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) step(1'b0, 8'h00, 1'b0);
      else step($urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)), 1'b1);
    end
    idle(100);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
